axis_packet_arbiter: RTL

Round-robin, packet-granular arbiter that shares one AXI4-Stream output between NUM_INPUTS stream sources, such as stream-source bench models or DMA readers. A grant is held from the first beat of a packet through its last beat, so packets are never interleaved. It sits between multiple stream producers and a single consumer or datapath port. It also reports the current grant and a forwarded-packet count.

---
 rtl/axis_packet_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/axis_packet_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : axis_packet_arbiter
//  Description : Packet-granular round-robin arbiter that shares one
//                AXI4-Stream output between NUM_INPUTS stream sources.
//                A grant is held from the first beat to the tlast beat so
//                packets are never interleaved. Reports the current grant
//                and a wrapping count of forwarded packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_packet_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    output logic [NUM_INPUTS-1:0]            in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]            in_last,
    input  logic [NUM_INPUTS*KEEP_WIDTH-1:0] in_keep,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic                             out_last,
    output logic [KEEP_WIDTH-1:0]            out_keep,
    output logic                             grant_valid,
    output logic [IDX_WIDTH-1:0]             grant_idx,
    output logic [15:0]                      pkt_count
);

    // Highest input index; loaded into the last-grant register at reset so
    // the first search starts at input 0.
    localparam logic [IDX_WIDTH-1:0] c_last_idx = IDX_WIDTH'(NUM_INPUTS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PASS = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IDX_WIDTH-1:0]    r_grant_idx;
    logic [IDX_WIDTH-1:0]    w_grant_next;
    logic [IDX_WIDTH-1:0]    r_last_grant;
    logic [IDX_WIDTH-1:0]    w_last_next;
    logic [15:0]             r_pkt_count;
    logic [15:0]             w_count_next;

    logic                    w_any_req;
    logic [IDX_WIDTH-1:0]    w_arb_idx;
    logic [IDX_WIDTH-1:0]    w_cand;

    logic                    w_sel_valid;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [KEEP_WIDTH-1:0]   w_sel_keep;
    logic                    w_sel_last;

    logic                    w_pass;
    logic                    w_fire;
    logic [NUM_INPUTS-1:0]   w_in_ready;

    // Round-robin search: walk from the farthest offset down to offset 1 so
    // the requester closest after the last grant is the one that sticks.
    always_comb begin
        w_any_req = 1'b0;
        w_arb_idx = '0;
        w_cand    = '0;
        for (int off = NUM_INPUTS; off >= 1; off--) begin
            w_cand = IDX_WIDTH'((int'(r_last_grant) + off) % NUM_INPUTS);
            if (in_valid[w_cand]) begin
                w_any_req = 1'b1;
                w_arb_idx = w_cand;
            end
        end
    end

    // Select the stream fields of the currently granted input.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_keep  = '0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (r_grant_idx == IDX_WIDTH'(i)) begin
                w_sel_valid = in_valid[i];
                w_sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_keep  = in_keep[i*KEEP_WIDTH +: KEEP_WIDTH];
                w_sel_last  = in_last[i];
            end
        end
    end

    // Pass-through is live only in PASS and never while reset is held, so a
    // packet interrupted by reset cannot move another beat.
    assign w_pass = (r_state == S_PASS) && !reset;
    assign w_fire = w_pass && w_sel_valid && out_ready;

    // Only the granted input sees tready, and it is driven from out_ready
    // alone; in_valid never feeds in_ready.
    always_comb begin
        w_in_ready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (w_pass && (r_grant_idx == IDX_WIDTH'(i))) begin
                w_in_ready[i] = out_ready;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = w_pass && w_sel_valid;
    assign out_data    = w_pass ? w_sel_data : '0;
    assign out_keep    = w_pass ? w_sel_keep : '0;
    assign out_last    = w_pass && w_sel_last;
    assign grant_valid = w_pass;
    assign grant_idx   = r_grant_idx;
    assign pkt_count   = r_pkt_count;

    // Next-state logic: arbitrate in IDLE, release the grant on a tlast handshake.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant_idx;
        w_last_next  = r_last_grant;
        w_count_next = r_pkt_count;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_grant_next = w_arb_idx;
                    w_state_next = S_PASS;
                end
            end
            S_PASS: begin
                if (w_fire && w_sel_last) begin
                    w_count_next = r_pkt_count + 16'd1;
                    w_last_next  = r_grant_idx;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and grant registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant_idx  <= '0;
            r_last_grant <= c_last_idx;
            r_pkt_count  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_grant_idx  <= w_grant_next;
            r_last_grant <= w_last_next;
            r_pkt_count  <= w_count_next;
        end
    end

endmodule
`default_nettype wire
